// File: rtl/i2c_passthru_infilter_ss_pkg.sv
// Shared constants for the I2C passthru input-conditioning path.
package i2c_passthru_infilter_ss_pkg;
    localparam logic I2C_IDLE_LVL           = 1'b1;
    localparam int   SYNC_STAGES_DEF        = 2;
    localparam int   FILT_CNT_DEF           = 3;
    localparam int   WIDTH_FILT_CNT_DEF     = 2;
endpackage

// File: rtl/i2c_passthru_infilter_ss_deglitch_line.sv
// One I2C line: synchroniser chain, stability counter and filtered level.
module i2c_passthru_deglitch_line
    import i2c_passthru_infilter_ss_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int FILT_CNT       = FILT_CNT_DEF,
    parameter int WIDTH_FILT_CNT = WIDTH_FILT_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_abandon
);
    localparam logic [WIDTH_FILT_CNT-1:0] CNT_MAX = WIDTH_FILT_CNT'(FILT_CNT - 1);

    logic [SYNC_STAGES-1:0]    r_sync;
    logic [WIDTH_FILT_CNT-1:0] r_cnt;
    logic                      r_lvl;
    logic                      r_abandon;
    logic                      w_s;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign o_lvl     = r_lvl;
    assign o_abandon = r_abandon;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= {SYNC_STAGES{I2C_IDLE_LVL}};
            r_cnt     <= '0;
            r_lvl     <= I2C_IDLE_LVL;
            r_abandon <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_abandon <= 1'b0;
            if (w_s == r_lvl) begin
                // Level returned before qualifying: the pending change is dropped.
                r_cnt     <= '0;
                r_abandon <= (r_cnt != '0);
            end else if (r_cnt == CNT_MAX) begin
                r_lvl <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/i2c_passthru_infilter_ss.sv
// Per-channel input conditioning: deglitched SCL/SDA plus START/STOP/edge events and bus-busy.
module i2c_passthru_infilter_ss
    import i2c_passthru_infilter_ss_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int FILT_CNT       = FILT_CNT_DEF,
    parameter int WIDTH_FILT_CNT = WIDTH_FILT_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_busy,
    output logic o_glitch
);
    logic w_scl, w_sda, w_scl_ab, w_sda_ab;
    logic w_start, w_stop;
    logic r_prev_scl, r_prev_sda;
    logic r_scl_rise, r_scl_fall, r_start, r_stop, r_busy;

    i2c_passthru_deglitch_line #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT), .WIDTH_FILT_CNT(WIDTH_FILT_CNT)
    ) u_scl (
        .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_scl), .o_lvl(w_scl), .o_abandon(w_scl_ab)
    );

    i2c_passthru_deglitch_line #(
        .SYNC_STAGES(SYNC_STAGES), .FILT_CNT(FILT_CNT), .WIDTH_FILT_CNT(WIDTH_FILT_CNT)
    ) u_sda (
        .i_clk(i_clk), .i_rst(i_rst), .i_pin(i_sda), .o_lvl(w_sda), .o_abandon(w_sda_ab)
    );

    // SCL must be high both before and after the SDA edge, so a joint change never qualifies.
    assign w_start = r_prev_sda & ~w_sda & r_prev_scl & w_scl;
    assign w_stop  = ~r_prev_sda & w_sda & r_prev_scl & w_scl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_scl <= I2C_IDLE_LVL;
            r_prev_sda <= I2C_IDLE_LVL;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_prev_scl <= w_scl;
            r_prev_sda <= w_sda;
            r_scl_rise <= w_scl & ~r_prev_scl;
            r_scl_fall <= ~w_scl & r_prev_scl;
            r_start    <= w_start;
            r_stop     <= w_stop;
            if (w_start)
                r_busy <= 1'b1;
            else if (w_stop)
                r_busy <= 1'b0;
        end
    end

    assign o_scl      = w_scl;
    assign o_sda      = w_sda;
    assign o_scl_rise = r_scl_rise;
    assign o_scl_fall = r_scl_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_busy     = r_busy;
    assign o_glitch   = w_scl_ab | w_sda_ab;
endmodule
